// File: rtl/net_arb_ctrl_axil_master.sv
// AXI4-Lite initiator: writes the arbiter trust-mode register, reads it back to confirm.
// Ports: cmd_* request, rsp_* completion, cur_trusted mirror, timeout_flag, m_axi_* AXI-Lite master.
module net_arb_ctrl_axil_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = '0,
  parameter logic [DATA_W-1:0] TRUST_VAL = {{(DATA_W-1){1'b0}}, 1'b1},
  parameter logic [DATA_W-1:0] UNTRUST_VAL = '0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_trusted,
  output logic              rsp_valid,
  output logic [1:0]        rsp_code,
  output logic              cur_trusted,
  output logic              timeout_flag,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR, WAIT_B, RD, WAIT_R, DONE
  } state_t;

  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  state_t            state, state_n;
  logic [1:0]        code, code_n;
  logic              cmd_t;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done, w_done;
  logic [7:0]        cnt, cnt_inc;
  logic              to_flag;
  logic              cur_t;
  logic              wait_st;

  assign cnt_inc = cnt + 8'd1;
  assign wait_st = (state == WR) || (state == WAIT_B) ||
                   (state == RD) || (state == WAIT_R);

  assign m_axi_awaddr = CTRL_ADDR;
  assign m_axi_awprot = 3'b000;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = '1;
  assign m_axi_araddr = CTRL_ADDR;
  assign m_axi_arprot = 3'b000;
  assign rsp_code     = code;
  assign cur_trusted  = cur_t;
  assign timeout_flag = to_flag;

  always_comb begin
    state_n       = state;
    code_n        = code;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          code_n  = 2'd0;
          state_n = WR;
        end
      end
      WR: begin
        // each channel's valid drops on its own once accepted
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready))
          state_n = WAIT_B;
      end
      WAIT_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            code_n  = 2'd1;
            state_n = DONE;
          end else begin
            state_n = RD;
          end
        end
      end
      RD: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_n = WAIT_R;
      end
      WAIT_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) code_n = 2'd1;
          else if (m_axi_rdata != wdata_q) code_n = 2'd2;
          else if (to_flag) code_n = 2'd3;
          else code_n = 2'd0;
          state_n = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      code    <= 2'd0;
      cmd_t   <= 1'b1;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      cnt     <= 8'd0;
      to_flag <= 1'b0;
      cur_t   <= 1'b1;
    end else begin
      state <= state_n;
      code  <= code_n;
      if (state == IDLE && cmd_valid) begin
        cmd_t   <= cmd_trusted;
        wdata_q <= cmd_trusted ? TRUST_VAL : UNTRUST_VAL;
      end
      if (state != WR) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
        if (m_axi_wvalid && m_axi_wready) w_done <= 1'b1;
      end
      // stall counter restarts on every state change, saturates at TO_MAX
      if (state != state_n) cnt <= 8'd0;
      else if (wait_st && cnt != TO_MAX) cnt <= cnt_inc;
      if (state == IDLE) to_flag <= 1'b0;
      else if (wait_st && state == state_n && cnt != TO_MAX && cnt_inc == TO_MAX)
        to_flag <= 1'b1;
      if (state == DONE && (code == 2'd0 || code == 2'd3)) cur_t <= cmd_t;
    end
  end

endmodule

// File: tb/tb_net_arb_ctrl_axil_master.sv
// Self-checking bench for net_arb_ctrl_axil_master.
// Directed scenarios plus randomized transactions against a behavioural model.
module tb_net_arb_ctrl_axil_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_trusted;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic        cur_trusted, timeout_flag;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;

  int n_chk = 0;
  int n_fail = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int ar_hs = 0;
  bit model_cur;

  always #5 clk = ~clk;

  net_arb_ctrl_axil_master dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_trusted(cmd_trusted),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .cur_trusted(cur_trusted), .timeout_flag(timeout_flag),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always @(posedge clk) begin
    if (resetn) begin
      if (m_axi_awvalid && m_axi_awready) aw_hs <= aw_hs + 1;
      if (m_axi_wvalid && m_axi_wready) w_hs <= w_hs + 1;
      if (m_axi_arvalid && m_axi_arready) ar_hs <= ar_hs + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the register controller should report for one command.
  function automatic logic [1:0] model_code(input bit t, input logic [1:0] br,
                                            input logic [1:0] rr,
                                            input logic [31:0] rd,
                                            input bit timed_out);
    logic [31:0] word;
    word = t ? 32'h1 : 32'h0;
    if (br != 2'b00) return 2'd1;
    if (rr != 2'b00) return 2'd1;
    if (rd != word) return 2'd2;
    if (timed_out) return 2'd3;
    return 2'd0;
  endfunction

  task automatic all_ready();
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    m_axi_bvalid  = 1'b1;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b1;
  endtask

  // Called at a negedge. Issues one command and follows it to rsp_valid,
  // then advances one more cycle. Checks AXI field stability on the way.
  task automatic run(input bit t, input bit rnd, input int wdly,
                     input int ardly, input string tag,
                     output int lat, output logic [1:0] code,
                     output int aw_hi, output int w_hi, output int ar_hi,
                     output bit to_a, output bit to_b);
    int cyc;
    int bad;
    bit got;
    bit p_aw, p_w, p_ar;
    logic [31:0] exp_w;
    exp_w = t ? 32'h1 : 32'h0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    to_a = 1'b0; to_b = 1'b0;
    bad = 0; got = 1'b0; code = 2'd0;
    p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    if (wdly > 0) m_axi_wready = 1'b0;
    if (ardly > 0) m_axi_arready = 1'b0;
    cmd_valid = 1'b1;
    cmd_trusted = t;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!got && cyc < 2000) begin
      if (rsp_valid) begin
        got = 1'b1;
        code = rsp_code;
      end else begin
        if (p_aw && !m_axi_awvalid) bad++;
        if (p_w && !m_axi_wvalid) bad++;
        if (p_ar && !m_axi_arvalid) bad++;
        if (m_axi_awvalid) begin
          aw_hi++;
          if (m_axi_awaddr !== 32'h0 || m_axi_awprot !== 3'b000) bad++;
        end
        if (m_axi_wvalid) begin
          w_hi++;
          if (m_axi_wdata !== exp_w || m_axi_wstrb !== 4'hF) bad++;
        end
        if (m_axi_arvalid) begin
          ar_hi++;
          if (m_axi_araddr !== 32'h0 || m_axi_arprot !== 3'b000) bad++;
          if (ar_hi == 255) to_a = timeout_flag;
          if (ar_hi == 256) to_b = timeout_flag;
        end
        if (rnd) begin
          m_axi_awready = 1'($urandom_range(0, 1));
          m_axi_wready  = 1'($urandom_range(0, 1));
          m_axi_bvalid  = 1'($urandom_range(0, 1));
          m_axi_arready = 1'($urandom_range(0, 1));
          m_axi_rvalid  = 1'($urandom_range(0, 1));
        end
        if (wdly > 0) m_axi_wready = (cyc > wdly);
        if (ardly > 0) m_axi_arready = (ar_hi >= ardly);
        p_aw = m_axi_awvalid && !m_axi_awready;
        p_w  = m_axi_wvalid && !m_axi_wready;
        p_ar = m_axi_arvalid && !m_axi_arready;
        @(negedge clk);
        cyc++;
      end
    end
    lat = cyc;
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_axi_stable"}, bad, 0);
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat, aw_hi, w_hi, ar_hi, a0, w0, r0, cyc;
    logic [1:0] code, ec;
    bit to_a, to_b, t;

    resetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_trusted = 1'b0;
    m_axi_bresp = 2'b00;
    m_axi_rresp = 2'b00;
    m_axi_rdata = 32'h0;
    all_ready();
    model_cur = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready, rsp_valid}, 32'd0);
    chk("rst_code", 32'(rsp_code), 32'd0);
    chk("rst_cur", 32'(cur_trusted), 32'd1);
    chk("rst_to", 32'(timeout_flag), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: immediate slave, untrusted
    a0 = aw_hs; w0 = w_hs; r0 = ar_hs;
    m_axi_rdata = 32'h0;
    run(1'b0, 1'b0, 0, 0, "t1", lat, code, aw_hi, w_hi, ar_hi, to_a, to_b);
    model_cur = 1'b0;
    chk("t1_latency", lat, 5);
    chk("t1_code", 32'(code), 32'd0);
    chk("t1_cur", 32'(cur_trusted), 32'(model_cur));
    chk("t1_aw_hs", aw_hs - a0, 1);
    chk("t1_ar_hs", ar_hs - r0, 1);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);

    // 2: wready delayed 3 cycles
    a0 = aw_hs; w0 = w_hs;
    m_axi_rdata = 32'h1;
    run(1'b1, 1'b0, 3, 0, "t2", lat, code, aw_hi, w_hi, ar_hi, to_a, to_b);
    model_cur = 1'b1;
    chk("t2_aw_cycles", aw_hi, 1);
    chk("t2_w_cycles", w_hi, 4);
    chk("t2_aw_hs", aw_hs - a0, 1);
    chk("t2_w_hs", w_hs - w0, 1);
    chk("t2_code", 32'(code), 32'd0);
    chk("t2_cur", 32'(cur_trusted), 32'(model_cur));
    all_ready();

    // 3: write error response
    r0 = ar_hs;
    m_axi_bresp = 2'b10;
    m_axi_rdata = 32'h0;
    run(1'b0, 1'b0, 0, 0, "t3", lat, code, aw_hi, w_hi, ar_hi, to_a, to_b);
    chk("t3_ar_cycles", ar_hi, 0);
    chk("t3_ar_hs", ar_hs - r0, 0);
    chk("t3_code", 32'(code), 32'd1);
    chk("t3_cur", 32'(cur_trusted), 32'(model_cur));
    m_axi_bresp = 2'b00;

    // 4: readback mismatch
    m_axi_rdata = 32'h1;
    run(1'b0, 1'b0, 0, 0, "t4", lat, code, aw_hi, w_hi, ar_hi, to_a, to_b);
    chk("t4_code", 32'(code), 32'd2);
    chk("t4_cur", 32'(cur_trusted), 32'd1);

    // 5: arready withheld 300 cycles
    m_axi_rdata = 32'h0;
    run(1'b0, 1'b0, 0, 300, "t5", lat, code, aw_hi, w_hi, ar_hi, to_a, to_b);
    model_cur = 1'b0;
    chk("t5_to_at_254", 32'(to_a), 32'd0);
    chk("t5_to_at_255", 32'(to_b), 32'd1);
    chk("t5_ar_cycles", ar_hi, 300);
    chk("t5_code", 32'(code), 32'd3);
    chk("t5_cur", 32'(cur_trusted), 32'(model_cur));
    all_ready();

    // 6: reset while waiting for the write response
    m_axi_bvalid = 1'b0;
    cmd_valid = 1'b1;
    cmd_trusted = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!m_axi_bready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_in_wait_b", 32'(m_axi_bready), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_cur = 1'b1;
    chk("t6_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                      m_axi_bready, m_axi_rready}, 32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_cur", 32'(cur_trusted), 32'd1);
    m_axi_bvalid = 1'b1;
    cyc = 0;
    repeat (4) begin
      if (rsp_valid) cyc++;
      @(negedge clk);
    end
    chk("t6_no_rsp", cyc, 0);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      t = 1'($urandom_range(0, 1));
      m_axi_bresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m_axi_rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m_axi_rdata = ($urandom_range(0, 3) == 0) ? 32'(!t) : 32'(t);
      ec = model_code(t, m_axi_bresp, m_axi_rresp, m_axi_rdata, 1'b0);
      a0 = aw_hs; w0 = w_hs; r0 = ar_hs;
      run(t, 1'b1, 0, 0, "rnd", lat, code, aw_hi, w_hi, ar_hi, to_a, to_b);
      if (ec == 2'd0 || ec == 2'd3) model_cur = t;
      chk("rnd_code", 32'(code), 32'(ec));
      chk("rnd_cur", 32'(cur_trusted), 32'(model_cur));
      chk("rnd_hs", {aw_hs - a0, w_hs - w0, ar_hs - r0},
          {32'd1, 32'd1, (m_axi_bresp == 2'b00) ? 32'd1 : 32'd0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
